// File: rtl/iob_merge2.sv
// Two-master to one-slave merge on the native valid/ready bus.
// Round-robin arbitration by default; define MERGE2_FIXED_PRIO_EN for fixed m0 priority.

`ifndef REQ_W
`define REQ_W (1 + ADDR_W + DATA_W + DATA_W / 8)
`endif
`ifndef RESP_W
`define RESP_W (DATA_W + 1)
`endif

module iob_merge2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [`REQ_W-1:0]   m0_req,
    output logic [`RESP_W-1:0]  m0_resp,
    input  logic [`REQ_W-1:0]   m1_req,
    output logic [`RESP_W-1:0]  m1_resp,
    output logic [`REQ_W-1:0]   s_req,
    input  logic [`RESP_W-1:0]  s_resp
);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t state;
    logic   owner;
`ifndef MERGE2_FIXED_PRIO_EN
    logic   last;
`endif

    logic m0_valid;
    logic m1_valid;
    logic any_valid;
    logic s_ready;
    logic winner;
    logic sel;
    logic active;

    // Request bus layout is {valid, address, wdata, wstrb}; response is {rdata, ready}.
    assign m0_valid  = m0_req[`REQ_W-1];
    assign m1_valid  = m1_req[`REQ_W-1];
    assign any_valid = m0_valid | m1_valid;
    assign s_ready   = s_resp[0];

    always_comb begin
        winner = 1'b0;
        if (m0_valid && m1_valid) begin
`ifdef MERGE2_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last;
`endif
        end else if (m1_valid) begin
            winner = 1'b1;
        end
    end

    // In BUSY the owner keeps the slave even if it drops valid; only slave ready frees it.
    assign sel    = (state == StBusy) ? owner : winner;
    assign active = (state == StBusy) | any_valid;

    always_comb begin
        s_req   = '0;
        m0_resp = '0;
        m1_resp = '0;
        if (active) begin
            if (sel) begin
                s_req   = m1_req;
                m1_resp = s_resp;
            end else begin
                s_req   = m0_req;
                m0_resp = s_resp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            owner <= 1'b0;
`ifndef MERGE2_FIXED_PRIO_EN
            last  <= 1'b1;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_valid) begin
                        if (s_ready) begin
`ifndef MERGE2_FIXED_PRIO_EN
                            last <= winner;
`endif
                        end else begin
                            state <= StBusy;
                            owner <= winner;
                        end
                    end
                end
                StBusy: begin
                    if (s_ready) begin
`ifndef MERGE2_FIXED_PRIO_EN
                        last <= owner;
`endif
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
